// File: rtl/csr_unit.sv
// Machine-mode CSR file for the writeback trap interface.
// Holds status/trap state, gated interrupt requests and 64-bit counters.
module csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h00000000,
    parameter logic [31:0] MISA_VALUE  = 32'h40000100,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] read_address,
    output logic [31:0] read_data,
    output logic        read_valid,
    input  logic        csr_write,
    input  logic [11:0] csr_address,
    input  logic [31:0] csr_data,
    input  logic        traped,
    input  logic        mret,
    input  logic        retired,
    input  logic [31:0] ecp,
    input  logic [3:0]  ecause,
    input  logic        interupt,
    input  logic        ext_software,
    input  logic        ext_timer,
    input  logic        ext_external,
    output logic        sip,
    output logic        tip,
    output logic        eip,
    output logic [31:0] trap_vector,
    output logic [31:0] mret_vector
);

    logic        st_mie, st_mpie;
    logic        ie_s, ie_t, ie_e;
    logic        ip_s, ip_t, ip_e;
    logic [31:0] mtvec, mscratch, mepc;
    logic        mcause_int;
    logic [3:0]  mcause_code;
    logic [63:0] mcycle, minstret;
    logic        wr;
    logic        cyc_lo, cyc_hi, ins_lo, ins_hi;
    logic [31:0] tv_base;

    // A trap or mret in the same cycle swallows any CSR write.
    assign wr     = csr_write & ~traped & ~mret;
    assign cyc_lo = wr && (csr_address == 12'hB00);
    assign cyc_hi = wr && (csr_address == 12'hB80);
    assign ins_lo = wr && (csr_address == 12'hB02);
    assign ins_hi = wr && (csr_address == 12'hB82);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_mie      <= 1'b0;
            st_mpie     <= 1'b0;
            ie_s        <= 1'b0;
            ie_t        <= 1'b0;
            ie_e        <= 1'b0;
            ip_s        <= 1'b0;
            ip_t        <= 1'b0;
            ip_e        <= 1'b0;
            mtvec       <= MTVEC_RESET & 32'hFFFF_FFFD;
            mscratch    <= 32'd0;
            mepc        <= 32'd0;
            mcause_int  <= 1'b0;
            mcause_code <= 4'd0;
        end else begin
            ip_s <= ext_software;
            ip_t <= ext_timer;
            ip_e <= ext_external;
            if (traped) begin
                mepc        <= ecp & 32'hFFFF_FFFC;
                mcause_int  <= interupt;
                mcause_code <= ecause;
                st_mpie     <= st_mie;
                st_mie      <= 1'b0;
            end else if (mret) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (csr_write) begin
                case (csr_address)
                    12'h300: begin
                        st_mie  <= csr_data[3];
                        st_mpie <= csr_data[7];
                    end
                    12'h304: begin
                        ie_s <= csr_data[3];
                        ie_t <= csr_data[7];
                        ie_e <= csr_data[11];
                    end
                    12'h305: mtvec    <= csr_data & 32'hFFFF_FFFD;
                    12'h340: mscratch <= csr_data;
                    12'h341: mepc     <= csr_data & 32'hFFFF_FFFC;
                    12'h342: begin
                        mcause_int  <= csr_data[31];
                        mcause_code <= csr_data[3:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcycle   <= 64'd0;
            minstret <= 64'd0;
        end else begin
            if (cyc_lo)      mcycle[31:0]  <= csr_data;
            else if (cyc_hi) mcycle[63:32] <= csr_data;
            else             mcycle        <= mcycle + 64'd1;
            if (ins_lo)       minstret[31:0]  <= csr_data;
            else if (ins_hi)  minstret[63:32] <= csr_data;
            else if (retired) minstret        <= minstret + 64'd1;
        end
    end

    assign sip = st_mie & ie_s & ip_s;
    assign tip = st_mie & ie_t & ip_t;
    assign eip = st_mie & ie_e & ip_e;

    assign tv_base     = {mtvec[31:2], 2'b00};
    assign trap_vector = (mtvec[0] && interupt)
                       ? tv_base + {26'd0, ecause, 2'b00}
                       : tv_base;
    assign mret_vector = mepc;

    always_comb begin
        read_data  = 32'd0;
        read_valid = 1'b1;
        case (read_address)
            12'h300: read_data = {24'd0, st_mpie, 3'd0, st_mie, 3'd0};
            12'h301: read_data = MISA_VALUE;
            12'h304: read_data = {20'd0, ie_e, 3'd0, ie_t, 3'd0, ie_s, 3'd0};
            12'h305: read_data = mtvec;
            12'h340: read_data = mscratch;
            12'h341: read_data = mepc;
            12'h342: read_data = {mcause_int, 27'd0, mcause_code};
            12'h343: read_data = 32'd0;
            12'h344: read_data = {20'd0, ip_e, 3'd0, ip_t, 3'd0, ip_s, 3'd0};
            12'hF11, 12'hF12, 12'hF13: read_data = 32'd0;
            12'hF14: read_data = HART_ID;
            12'hB00, 12'hC00: read_data = mcycle[31:0];
            12'hB80, 12'hC80: read_data = mcycle[63:32];
            12'hB02, 12'hC02: read_data = minstret[31:0];
            12'hB82, 12'hC82: read_data = minstret[63:32];
            default: read_valid = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit: directed test-plan steps followed
// by random traffic compared against a behavioural CSR model.
module tb_csr_unit;

    logic        clk, reset;
    logic [11:0] read_address;
    logic [31:0] read_data;
    logic        read_valid;
    logic        csr_write;
    logic [11:0] csr_address;
    logic [31:0] csr_data;
    logic        traped, mret, retired;
    logic [31:0] ecp;
    logic [3:0]  ecause;
    logic        interupt;
    logic        ext_software, ext_timer, ext_external;
    logic        sip, tip, eip;
    logic [31:0] trap_vector, mret_vector;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mstatus, m_mie, m_mip, m_mtvec, m_mscratch;
    logic [31:0] m_mepc, m_mcause;
    logic [63:0] m_mcycle, m_minstret;

    logic [11:0] addrs [0:24] = '{
        12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
        12'h343, 12'h344, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'hB00,
        12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82,
        12'h7C0, 12'h000, 12'h3A0, 12'hB03};

    csr_unit dut (
        .clk(clk), .reset(reset),
        .read_address(read_address), .read_data(read_data),
        .read_valid(read_valid),
        .csr_write(csr_write), .csr_address(csr_address),
        .csr_data(csr_data),
        .traped(traped), .mret(mret), .retired(retired),
        .ecp(ecp), .ecause(ecause), .interupt(interupt),
        .ext_software(ext_software), .ext_timer(ext_timer),
        .ext_external(ext_external),
        .sip(sip), .tip(tip), .eip(eip),
        .trap_vector(trap_vector), .mret_vector(mret_vector)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mstatus = 0; m_mie = 0; m_mip = 0; m_mscratch = 0;
        m_mepc = 0; m_mcause = 0; m_mtvec = 32'h0;
        m_mcycle = 0; m_minstret = 0;
    endtask

    task automatic model_read(input logic [11:0] a, output logic v,
                              output logic [31:0] d);
        v = 1'b1;
        d = 32'd0;
        case (a)
            12'h300: d = m_mstatus;
            12'h301: d = 32'h40000100;
            12'h304: d = m_mie;
            12'h305: d = m_mtvec;
            12'h340: d = m_mscratch;
            12'h341: d = m_mepc;
            12'h342: d = m_mcause;
            12'h344: d = m_mip;
            12'h343, 12'hF11, 12'hF12, 12'hF13, 12'hF14: d = 32'd0;
            12'hB00, 12'hC00: d = m_mcycle[31:0];
            12'hB80, 12'hC80: d = m_mcycle[63:32];
            12'hB02, 12'hC02: d = m_minstret[31:0];
            12'hB82, 12'hC82: d = m_minstret[63:32];
            default: v = 1'b0;
        endcase
    endtask

    task automatic model_update();
        logic cl, ch, il, ih;
        cl = 0; ch = 0; il = 0; ih = 0;
        if (traped) begin
            m_mepc    = ecp & ~32'h3;
            m_mcause  = {interupt, 27'd0, ecause};
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
        end else if (mret) begin
            m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end else if (csr_write) begin
            case (csr_address)
                12'h300: m_mstatus  = csr_data & 32'h88;
                12'h304: m_mie      = csr_data & 32'h888;
                12'h305: m_mtvec    = csr_data & ~32'h2;
                12'h340: m_mscratch = csr_data;
                12'h341: m_mepc     = csr_data & ~32'h3;
                12'h342: m_mcause   = csr_data & 32'h8000000F;
                12'hB00: cl = 1;
                12'hB80: ch = 1;
                12'hB02: il = 1;
                12'hB82: ih = 1;
                default: ;
            endcase
        end
        if (cl)      m_mcycle = {m_mcycle[63:32], csr_data};
        else if (ch) m_mcycle = {csr_data, m_mcycle[31:0]};
        else         m_mcycle = m_mcycle + 64'd1;
        if (il)      m_minstret = {m_minstret[63:32], csr_data};
        else if (ih) m_minstret = {csr_data, m_minstret[31:0]};
        else         m_minstret = m_minstret + 64'(retired);
        m_mip = {20'd0, ext_external, 3'd0, ext_timer, 3'd0,
                 ext_software, 3'd0};
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic rd(input logic [11:0] a, output logic v,
                      output logic [31:0] d);
        read_address = a;
        #1;
        v = read_valid;
        d = read_data;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_write = 1; csr_address = a; csr_data = d;
        tick();
        csr_write = 0;
    endtask

    task automatic chk_model_outputs(input string tag);
        logic [31:0] base, tv;
        base = m_mtvec & ~32'h3;
        tv = (m_mtvec[1:0] == 2'd1 && interupt) ? base + 4 * ecause : base;
        chk({tag, "_sip"}, sip, m_mstatus[3] & m_mie[3] & m_mip[3]);
        chk({tag, "_tip"}, tip, m_mstatus[3] & m_mie[7] & m_mip[7]);
        chk({tag, "_eip"}, eip, m_mstatus[3] & m_mie[11] & m_mip[11]);
        chk({tag, "_tvec"}, trap_vector, tv);
        chk({tag, "_mvec"}, mret_vector, m_mepc);
    endtask

    task automatic chk_read(input string tag, input logic [11:0] a);
        logic v, ev;
        logic [31:0] d, ed;
        rd(a, v, d);
        model_read(a, ev, ed);
        chk({tag, "_valid"}, v, ev);
        chk({tag, "_data"}, d, ed);
    endtask

    initial begin
        logic v;
        logic [31:0] d, h0;
        reset = 1; read_address = 0; csr_write = 0; csr_address = 0;
        csr_data = 0; traped = 0; mret = 0; retired = 0; ecp = 0;
        ecause = 0; interupt = 0; ext_software = 0; ext_timer = 0;
        ext_external = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        model_reset();

        rd(12'h305, v, d);
        chk("rst_mtvec", d, 32'h0);
        chk("rst_mtvec_valid", v, 1'b1);
        rd(12'h7C0, v, d);
        chk("unimpl_valid", v, 1'b0);
        chk("unimpl_data", d, 32'h0);
        chk("rst_irq", {sip, tip, eip}, 3'b000);
        chk("rst_mret_vector", mret_vector, 32'h0);

        wr(12'h304, 32'h80);
        wr(12'h300, 32'h8);
        ext_timer = 1;
        #1 chk("tip_before_edge", tip, 1'b0);
        tick();
        chk("tip_after_edge", tip, 1'b1);
        wr(12'h300, 32'h0);
        chk("tip_mie_off", tip, 1'b0);
        wr(12'h300, 32'h8);
        chk("tip_mie_on", tip, 1'b1);

        traped = 1; interupt = 1; ecause = 4'd7; ecp = 32'h1006;
        tick();
        traped = 0;
        rd(12'h341, v, d); chk("trap_mepc", d, 32'h1004);
        rd(12'h342, v, d); chk("trap_mcause", d, 32'h80000007);
        rd(12'h300, v, d); chk("trap_mstatus", d, 32'h80);
        chk("trap_tip_masked", tip, 1'b0);
        mret = 1;
        tick();
        mret = 0;
        rd(12'h300, v, d); chk("mret_mstatus", d, 32'h88);
        chk("mret_vector", mret_vector, 32'h1004);

        wr(12'h305, 32'h2003);
        rd(12'h305, v, d); chk("mtvec_vec", d, 32'h2001);
        interupt = 1; ecause = 4'd11;
        #1 chk("tvec_int11", trap_vector, 32'h202C);
        interupt = 0; ecause = 4'd2;
        #1 chk("tvec_exc2", trap_vector, 32'h2000);

        chk_read("cyc0", 12'hB00);
        tick();
        chk_read("cyc1", 12'hC00);
        retired = 1; tick(); tick();
        retired = 0; tick();
        chk_read("instret", 12'hB02);
        h0 = m_mcycle[63:32];
        wr(12'hB00, 32'hFFFFFFFF);
        rd(12'hB00, v, d); chk("cyc_wr_lo", d, 32'hFFFFFFFF);
        rd(12'hB80, v, d); chk("cyc_wr_hi", d, h0);
        tick();
        rd(12'hB00, v, d); chk("cyc_carry_lo", d, 32'h0);
        rd(12'hB80, v, d); chk("cyc_carry_hi", d, h0 + 1);
        wr(12'hC00, 32'h12345678);
        chk_read("cyc_c00_ro", 12'hB00);
        wr(12'hB80, 32'hFFFFFFFF);
        wr(12'hB00, 32'hFFFFFFFE);
        tick();
        rd(12'hB80, v, d); chk("wrap_hi_max", d, 32'hFFFFFFFF);
        tick();
        rd(12'hB00, v, d); chk("wrap_lo", d, 32'h0);
        rd(12'hB80, v, d); chk("wrap_hi", d, 32'h0);

        wr(12'h340, 32'hA5A5A5A5);
        traped = 1; mret = 1; csr_write = 1; csr_address = 12'h340;
        csr_data = 32'h0; ecp = 32'h3000; interupt = 0; ecause = 4'd3;
        tick();
        traped = 0; mret = 0; csr_write = 0;
        rd(12'h340, v, d); chk("prio_mscratch", d, 32'hA5A5A5A5);
        rd(12'h300, v, d); chk("prio_mstatus", d, 32'h80);
        rd(12'h341, v, d); chk("prio_mepc", d, 32'h3000);

        for (int i = 0; i < 400; i++) begin
            csr_write    = ($urandom_range(0, 2) == 0);
            csr_address  = addrs[$urandom_range(0, 24)];
            csr_data     = $urandom;
            traped       = ($urandom_range(0, 15) == 0);
            mret         = ($urandom_range(0, 15) == 0);
            retired      = $urandom_range(0, 1) == 1;
            ecp          = $urandom;
            ecause       = 4'($urandom_range(0, 15));
            interupt     = $urandom_range(0, 1) == 1;
            ext_software = $urandom_range(0, 1) == 1;
            ext_timer    = $urandom_range(0, 1) == 1;
            ext_external = $urandom_range(0, 1) == 1;
            chk_read("rnd", addrs[$urandom_range(0, 24)]);
            chk_model_outputs("rnd");
            tick();
        end

        reset = 1;
        #1;
        model_reset();
        chk_model_outputs("arst");
        chk_read("arst_mcycle", 12'hB00);
        chk_read("arst_mtvec", 12'h305);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
